// File: rtl/prox_pkg.sv
// Shared types and widths for the proximity tracker: FSM state encoding and datapath widths.
package prox_pkg;

  localparam int DIST_W = 16;
  localparam int IDLE_W = 6;
  localparam int HIT_W  = 4;

  typedef enum logic [1:0] {
    FAR      = 2'd0,
    APPROACH = 2'd1,
    NEAR     = 2'd2,
    LEAVE    = 2'd3
  } prox_state_e;

endpackage

// File: rtl/sec_tick.sv
// One-second prescaler: counts 0..CLK_HZ-1 and flags the cycle on which the count wraps.
// A synchronous clear restarts the second so a full period elapses before the next tick.
module sec_tick #(
  parameter int CLK_HZ = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [CNT_W-1:0] cnt_q;

  assign tick = (cnt_q == CNT_W'(CLK_HZ - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/proximity_tracker.sv
// Debounced near/far tracker with hysteresis, idle-seconds timer and neglect flag.
// Optional stale-sensor watchdog enabled by defining PROXIMITY_STALE_WATCHDOG_EN.
//
//   state    | meaning
//   FAR      | user away, waiting for a first near sample
//   APPROACH | counting consecutive near samples toward HITS
//   NEAR     | user present, near output high
//   LEAVE    | counting consecutive far samples toward HITS, near still high
module proximity_tracker
  import prox_pkg::*;
#(
  parameter int CLK_HZ    = 50000000,
  parameter int NEAR_CM   = 5,
  parameter int HYST_CM   = 2,
  parameter int HITS      = 3,
  parameter int TIMEOUT_S = 60,
  parameter int STALE_CYC = 5000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DIST_W-1:0] dist_cm,
  input  logic              dist_valid,
  input  logic              enable,
  output logic              near,
  output logic              near_pulse,
  output logic [IDLE_W-1:0] idle_sec,
  output logic              neglect,
  output logic              sensor_fault
);

  localparam logic [DIST_W:0] FAR_LIMIT = (DIST_W + 1)'(NEAR_CM + HYST_CM);

  prox_state_e      state_q, state_d;
  logic [HIT_W-1:0] hit_q, hit_d;
  logic [HIT_W-1:0] hit_inc;
  logic             hit_done;
  logic             sample_ok, near_s, far_s;
  logic             stale_trip;
  logic             interaction;
  logic             tick;

  assign sample_ok = dist_valid && (dist_cm != '0);
  assign near_s    = sample_ok && (dist_cm <= DIST_W'(NEAR_CM));
  assign far_s     = sample_ok && ({1'b0, dist_cm} > FAR_LIMIT);
  assign hit_inc   = hit_q + HIT_W'(1);
  assign hit_done  = (hit_inc == HIT_W'(HITS));

`ifdef PROXIMITY_STALE_WATCHDOG_EN
  localparam int STALE_W = $clog2(STALE_CYC + 1);

  logic [STALE_W-1:0] stale_q;
  logic               fault_q;

  assign stale_trip   = !dist_valid && (stale_q == STALE_W'(STALE_CYC - 1));
  assign sensor_fault = fault_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stale_q <= '0;
      fault_q <= 1'b0;
    end else if (dist_valid) begin
      stale_q <= '0;
      fault_q <= 1'b0;
    end else begin
      if (stale_q != STALE_W'(STALE_CYC)) stale_q <= stale_q + STALE_W'(1);
      if (stale_trip) fault_q <= 1'b1;
    end
  end
`else
  // Watchdog compiled out; this only consumes STALE_CYC and is constant 0.
  assign stale_trip   = (STALE_CYC < 0);
  assign sensor_fault = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    hit_d   = hit_q;
    if (sample_ok) begin
      case (state_q)
        FAR: begin
          if (near_s) begin
            if (HITS == 1) begin
              state_d = NEAR;
              hit_d   = '0;
            end else begin
              state_d = APPROACH;
              hit_d   = HIT_W'(1);
            end
          end
        end
        APPROACH: begin
          if (near_s) begin
            if (hit_done) begin
              state_d = NEAR;
              hit_d   = '0;
            end else begin
              hit_d = hit_inc;
            end
          end else begin
            state_d = FAR;
            hit_d   = '0;
          end
        end
        NEAR: begin
          if (far_s) begin
            if (HITS == 1) begin
              state_d = FAR;
              hit_d   = '0;
            end else begin
              state_d = LEAVE;
              hit_d   = HIT_W'(1);
            end
          end
        end
        LEAVE: begin
          if (far_s) begin
            if (hit_done) begin
              state_d = FAR;
              hit_d   = '0;
            end else begin
              hit_d = hit_inc;
            end
          end else begin
            state_d = NEAR;
            hit_d   = '0;
          end
        end
        default: begin
          state_d = FAR;
          hit_d   = '0;
        end
      endcase
    end
    if (stale_trip) begin
      state_d = FAR;
      hit_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FAR;
      hit_q      <= '0;
      near       <= 1'b0;
      near_pulse <= 1'b0;
    end else begin
      state_q    <= state_d;
      hit_q      <= hit_d;
      near       <= (state_q == NEAR) || (state_q == LEAVE);
      near_pulse <= ((state_q == NEAR) || (state_q == LEAVE)) && !near;
    end
  end

  // Any interaction restarts the second as well as the idle count.
  assign interaction = enable || near;

  sec_tick #(.CLK_HZ(CLK_HZ)) u_sec_tick (
    .clk   (clk),
    .reset (reset),
    .clear (interaction),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_sec <= '0;
      neglect  <= 1'b0;
    end else if (interaction) begin
      idle_sec <= '0;
      neglect  <= 1'b0;
    end else if (tick && (idle_sec < IDLE_W'(TIMEOUT_S))) begin
      idle_sec <= idle_sec + IDLE_W'(1);
      neglect  <= ((idle_sec + IDLE_W'(1)) == IDLE_W'(TIMEOUT_S));
    end
  end

endmodule

// File: tb/tb_proximity_tracker.sv
// Randomized and directed bench for proximity_tracker against a cycle-level behavioural model.
module tb_proximity_tracker;

  localparam int CLK_HZ    = 10;
  localparam int NEAR_CM   = 5;
  localparam int HYST_CM   = 2;
  localparam int HITS      = 3;
  localparam int TIMEOUT_S = 4;
  localparam int STALE_CYC = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] dist_cm = '0;
  logic        dist_valid = 1'b0;
  logic        enable = 1'b0;
  logic        near, near_pulse, neglect, sensor_fault;
  logic [5:0]  idle_sec;

  always #5 clk = ~clk;

  proximity_tracker #(
    .CLK_HZ(CLK_HZ), .NEAR_CM(NEAR_CM), .HYST_CM(HYST_CM),
    .HITS(HITS), .TIMEOUT_S(TIMEOUT_S), .STALE_CYC(STALE_CYC)
  ) dut (
    .clk(clk), .reset(reset), .dist_cm(dist_cm), .dist_valid(dist_valid),
    .enable(enable), .near(near), .near_pulse(near_pulse),
    .idle_sec(idle_sec), .neglect(neglect), .sensor_fault(sensor_fault)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: a near/far level plus a streak of consecutive samples arguing for the other level.
  bit m_is_near, m_near_out, m_pulse, m_neglect, m_fault;
  int m_streak, m_idle, m_sub, m_quiet;

  task automatic model_reset();
    m_is_near = 0; m_near_out = 0; m_pulse = 0; m_neglect = 0; m_fault = 0;
    m_streak = 0; m_idle = 0; m_sub = 0; m_quiet = 0;
  endtask

  task automatic model_update(input bit r, input bit v, input int d, input bit e);
    bit inter, was_near, want;
    if (r) begin
      model_reset();
      return;
    end
    inter    = e || m_near_out;
    was_near = m_is_near;
    if (v && d != 0) begin
      want = m_is_near ? (d > NEAR_CM + HYST_CM) : (d <= NEAR_CM);
      m_streak = want ? m_streak + 1 : 0;
      if (m_streak == HITS) begin
        m_is_near = !m_is_near;
        m_streak  = 0;
      end
    end
`ifdef PROXIMITY_STALE_WATCHDOG_EN
    if (v) begin
      m_quiet = 0;
      m_fault = 0;
    end else if (m_quiet < STALE_CYC) begin
      m_quiet++;
      if (m_quiet == STALE_CYC) begin
        m_fault   = 1;
        m_is_near = 0;
        m_streak  = 0;
      end
    end
`endif
    m_pulse    = was_near && !m_near_out;
    m_near_out = was_near;
    if (inter) begin
      m_idle = 0;
      m_sub  = 0;
    end else if (m_sub == CLK_HZ - 1) begin
      m_sub = 0;
      if (m_idle < TIMEOUT_S) m_idle++;
    end else begin
      m_sub++;
    end
    m_neglect = (m_idle >= TIMEOUT_S);
  endtask

  task automatic compare_all();
    chk("near", near, m_near_out);
    chk("near_pulse", near_pulse, m_pulse);
    chk("idle_sec", idle_sec, m_idle);
    chk("neglect", neglect, m_neglect);
    chk("sensor_fault", sensor_fault, m_fault);
  endtask

  // Checks the outcome of the previous edge, then drives inputs for the next one.
  task automatic step(input bit r, input bit v, input int d, input bit e);
    @(negedge clk);
    compare_all();
    reset      = r;
    dist_valid = v;
    dist_cm    = 16'(d);
    enable     = e;
    model_update(r, v, d, e);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic sample(input int d);
    step(0, 1, d, 0);
  endtask

  initial begin
    bit found;
    int mode_cnt;
    bit quiet_mode;
    int r;

    model_reset();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("rst_near", near, 0);
    chk("rst_idle", idle_sec, 0);
    chk("rst_neglect", neglect, 0);

    // 20, 4, 4, 4 -> near rises one cycle after the third 4
    sample(20); sample(4); sample(4); sample(4);
    step(0, 0, 0, 0);
    chk("near_after_3rd", near, 0);
    step(0, 0, 0, 0);
    chk("near_rise", near, 1);
    chk("pulse_rise", near_pulse, 1);
    step(0, 0, 0, 0);
    chk("pulse_one_cycle", near_pulse, 0);

    // band samples keep NEAR; far with an ignored 0 drops it
    sample(6); sample(6); sample(6);
    idle_steps(3);
    chk("band_holds_near", near, 1);
    sample(8); sample(0); sample(8); sample(8);
    step(0, 0, 0, 0);
    chk("near_before_fall", near, 1);
    step(0, 0, 0, 0);
    chk("near_fall", near, 0);

    // 4, 4, 6, 4, 4 -> band resets the streak
    step(1, 0, 0, 0);
    sample(4); sample(4); sample(6); sample(4); sample(4);
    idle_steps(3);
    chk("band_resets_count", near, 0);

    // idle timer steps and saturates
    step(1, 0, 0, 0);
    idle_steps(40);
    chk("idle_at_39", idle_sec, 3);
    step(0, 0, 0, 0);
    chk("idle_at_40", idle_sec, 4);
    chk("neglect_at_40", neglect, 1);
    idle_steps(20);
    chk("idle_saturated", idle_sec, 4);

    // enable on the tick cycle with idle_sec=3
    step(1, 0, 0, 0);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      if (m_idle == 3 && m_sub == CLK_HZ - 1) begin
        found = 1;
        break;
      end
      step(0, 0, 0, 0);
    end
    chk("tick_search", found, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("en_on_tick_idle", idle_sec, 0);
    chk("en_on_tick_neglect", neglect, 0);
    idle_steps(9);
    chk("no_early_incr", idle_sec, 0);
    step(0, 0, 0, 0);
    chk("incr_after_10", idle_sec, 1);

`ifdef PROXIMITY_STALE_WATCHDOG_EN
    step(1, 0, 0, 0);
    sample(4); sample(4); sample(4);
    idle_steps(16);
    chk("fault_not_yet", sensor_fault, 0);
    chk("near_before_fault", near, 1);
    step(0, 0, 0, 0);
    chk("fault_set", sensor_fault, 1);
    step(0, 0, 0, 0);
    chk("fault_near_drop", near, 0);
    sample(20);
    step(0, 0, 0, 0);
    chk("fault_cleared", sensor_fault, 0);
`endif

    // randomized phase, with occasional quiet stretches for the watchdog
    mode_cnt   = 0;
    quiet_mode = 0;
    for (int i = 0; i < 3000; i++) begin
      bit v, e, rs;
      int d;
      if (mode_cnt == 0) begin
        quiet_mode = !quiet_mode && ($urandom_range(0, 2) == 0);
        mode_cnt   = quiet_mode ? 40 : 150;
      end
      mode_cnt--;
      v = quiet_mode ? ($urandom_range(0, 49) == 0) : ($urandom_range(0, 1) == 1);
      r = $urandom_range(0, 9);
      if (r <= 3)      d = $urandom_range(1, NEAR_CM);
      else if (r == 4) d = 0;
      else if (r <= 6) d = $urandom_range(NEAR_CM + 1, NEAR_CM + HYST_CM);
      else if (r <= 8) d = $urandom_range(NEAR_CM + HYST_CM + 1, 40);
      else             d = $urandom_range(0, 65535);
      e  = ($urandom_range(0, 39) == 0);
      rs = ($urandom_range(0, 699) == 0);
      step(rs, v, d, e);
    end

    @(negedge clk);
    compare_all();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
